fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the PC register (PCF) and consumes the next-PC value selected by the PC select mux.
- Issues one outstanding instruction-memory request at a time and tracks in-flight requests across control-flow redirects.
- Loads the IF/ID pipeline register (InstrD, PCD, PCPlus4D, ValidD) under decode-stage stall/flush control.
- Is the sequential end of the next-PC path: it generates PCPlus4F for the mux and registers the mux output PCnext.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PCF value after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in InstrD on reset, flush or no delivery.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- PCnext  input  64  next PC from the PC select mux.
- PCSrcE  input  2  PC source select; any non-zero value is a redirect (RedirectE).
- StallD  input  1  hold IF/ID contents.
- FlushD  input  1  invalidate IF/ID at next edge.
- ImemReadyF  input  1  memory accepts the request this cycle.
- ImemRvalidF  input  1  response data valid.
- ImemRdataF  input  32  fetched instruction.
- PCF  output  64  current fetch PC.
- PCPlus4F  output  64  PCF + 4, combinational, modulo 2^64.
- ImemReqF  output  1  request valid.
- ImemAddrF  output  64  request address; always equals PCF.
- InstrD  output  32  IF/ID instruction.
- PCD  output  64  IF/ID PC.
- PCPlus4D  output  64  IF/ID PC+4.
- ValidD  output  1  InstrD holds a real instruction.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - PCF=RESET_PC; state=REQ; ImemReqF=0 while rst_n=0.
  - InstrD=NOP_INSTR; PCD=0; PCPlus4D=0; ValidD=0; hold buffer cleared.
- PC load: every PCF update is PCF <= {PCnext[63:2],2'b00}.
  - PCnext equals PCPlus4F when PCSrcE=0, so a sequential advance and a redirect use the same path.
- FSM states: REQ, WAIT, KILL, HOLD. ImemReqF=1 only in REQ.
- REQ:
  - ImemReadyF=1 and no redirect: go to WAIT.
  - ImemReadyF=1 and redirect: PCF loads; go to KILL, because the accepted request is wrong-path.
  - ImemReadyF=0 and redirect: PCF loads; stay in REQ. The un-accepted request simply changes address.
- WAIT:
  - ImemRvalidF=1, no redirect, StallD=0: load IF/ID with {ImemRdataF, PCF, PCPlus4F}; ValidD=1; PCF loads; go to REQ.
  - ImemRvalidF=1, no redirect, StallD=1: store ImemRdataF, PCF and PCPlus4F in the hold buffer; go to HOLD. PCF does not change.
  - ImemRvalidF=1 and redirect: discard the data; PCF loads; go to REQ.
  - ImemRvalidF=0 and redirect: PCF loads; go to KILL.
- KILL:
  - Wait for ImemRvalidF, discard the data, go to REQ. The response is never visible in D.
  - Redirect in KILL: PCF loads; stay in KILL.
- HOLD:
  - StallD=0 and no redirect: IF/ID loads from the hold buffer; ValidD=1; PCF loads; go to REQ.
  - Redirect: drop the buffer; PCF loads; go to REQ.
- IF/ID update priority per edge:
  - FlushD=1: InstrD=NOP_INSTR, ValidD=0. Overrides everything, including a delivery that cycle.
  - Else StallD=1: all IF/ID registers hold.
  - Else delivery: load as above.
  - Else (no delivery): bubble, InstrD=NOP_INSTR, ValidD=0; PCD and PCPlus4D hold.
- Latency: the earliest ValidD=1 is 2 cycles after reset release, with ImemReadyF=1 on the first REQ cycle and ImemRvalidF=1 on the next. Best-case throughput is one instruction per 2 cycles.
- ImemRvalidF in REQ or HOLD is a protocol violation and is ignored.
- ImemAddrF is stable while ImemReqF=1 and ImemReadyF=0, unless a redirect occurs.

Test Plan:
1. Reset release, RESET_PC=0x1000, ready and rvalid 1-cycle memory, instructions A/B, PCSrcE=0 -> PCD=0x1000/InstrD=A, then PCD=0x1004/InstrD=B, each with ValidD=1, alternating with ValidD=0 bubbles.
2. In WAIT at PCF=0x1008, redirect with PCnext=0x2000 while ImemRvalidF=0; later rvalid data C -> C is never loaded; next ImemAddrF=0x2000; first ValidD=1 shows PCD=0x2000.
3. ImemReadyF=1 and redirect (PCnext=0x3002) in the same REQ cycle -> state KILL; PCF=0x3000; the following response is dropped.
4. StallD=1 when rvalid returns D at 0x1010, held 3 cycles -> IF/ID unchanged for 3 cycles; PCF stays 0x1010; after release PCD=0x1010/InstrD=D and ImemAddrF=0x1014.
5. FlushD=1 and StallD=1 in the same cycle as a delivery -> InstrD=0x00000013, ValidD=0; the delivered instruction is lost.
6. rst_n asserted in WAIT mid-transaction -> outputs immediately take reset values; the stale rvalid that follows is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if : instruction-memory request/response bus.
//
// Signals
//   ImemReqF     fetch -> mem  request valid
//   ImemAddrF    fetch -> mem  request address (64b, word aligned)
//   ImemReadyF   mem -> fetch  request accepted this cycle
//   ImemRvalidF  mem -> fetch  response data valid
//   ImemRdataF   mem -> fetch  fetched instruction (32b)
//
// Modports
//   master : the fetch unit (drives request, samples response)
//   slave  : the instruction memory
// ---------------------------------------------------------------------------
interface fetch_unit_if;
    logic        ImemReqF;
    logic [63:0] ImemAddrF;
    logic        ImemReadyF;
    logic        ImemRvalidF;
    logic [31:0] ImemRdataF;

    modport master (
        output ImemReqF,
        output ImemAddrF,
        input  ImemReadyF,
        input  ImemRvalidF,
        input  ImemRdataF
    );

    modport slave (
        input  ImemReqF,
        input  ImemAddrF,
        output ImemReadyF,
        output ImemRvalidF,
        output ImemRdataF
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit : instruction-fetch stage.
//
// Owns the fetch PC, keeps at most one instruction-memory request in flight,
// discards responses that belong to a path abandoned by a redirect, and
// loads the IF/ID pipeline register under decode stall/flush control.
//
// Ports
//   clk, rst_n   core clock, asynchronous active-low reset
//   PCnext       next PC from the PC select mux (low two bits ignored)
//   PCSrcE       PC source select; non-zero means redirect
//   StallD       hold IF/ID contents
//   FlushD       invalidate IF/ID at the next edge
//   imem         instruction-memory bus (master side)
//   PCF          current fetch PC
//   PCPlus4F     PCF + 4 (combinational, wraps modulo 2^64)
//   InstrD       IF/ID instruction (NOP_INSTR when no valid instruction)
//   PCD          IF/ID PC
//   PCPlus4D     IF/ID PC + 4
//   ValidD       InstrD holds a real instruction
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [63:0]         PCnext,
    input  logic [1:0]          PCSrcE,
    input  logic                StallD,
    input  logic                FlushD,
    fetch_unit_if.master        imem,
    output logic [63:0]         PCF,
    output logic [63:0]         PCPlus4F,
    output logic [31:0]         InstrD,
    output logic [63:0]         PCD,
    output logic [63:0]         PCPlus4D,
    output logic                ValidD
);

    // REQ : request presented on the bus
    // WAIT: request accepted, response pending and still wanted
    // KILL: request accepted, response pending but wrong-path
    // HOLD: response captured while decode was stalled
    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_KILL = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]  r_state;
    logic [63:0] r_pcf;
    logic [31:0] r_hold_instr;
    logic [63:0] r_hold_pc;
    logic [63:0] r_hold_pc4;
    logic [31:0] r_instr_d;
    logic [63:0] r_pc_d;
    logic [63:0] r_pc4_d;
    logic        r_valid_d;

    logic [1:0]  w_state_next;
    logic        w_redirect;
    logic        w_stall;
    logic [63:0] w_pc_plus4;
    logic [63:0] w_pc_target;
    logic        w_pc_load;
    logic        w_deliver;
    logic        w_hold_load;
    logic [31:0] w_del_instr;
    logic [63:0] w_del_pc;
    logic [63:0] w_del_pc4;

    assign w_redirect  = |PCSrcE;
    assign w_pc_plus4  = r_pcf + 64'd4;
    assign w_pc_target = PCnext & ~64'h3;

    // A flush wipes IF/ID regardless of StallD, so a flushed stall must not
    // park the response in the hold buffer: it is delivered straight into
    // the flushed register and lost, and fetch moves on.
    assign w_stall = StallD & ~FlushD;

    // NOTE: every signal written here gets a default first so that no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_pc_load    = 1'b0;
        w_deliver    = 1'b0;
        w_hold_load  = 1'b0;
        w_del_instr  = imem.ImemRdataF;
        w_del_pc     = r_pcf;
        w_del_pc4    = w_pc_plus4;

        case (r_state)
            ST_REQ: begin
                // An un-accepted request just retargets; an accepted one that
                // coincides with a redirect is already wrong-path.
                w_pc_load = w_redirect;
                if (imem.ImemReadyF) begin
                    w_state_next = w_redirect ? ST_KILL : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.ImemRvalidF) begin
                    if (w_redirect) begin
                        w_pc_load    = 1'b1;
                        w_state_next = ST_REQ;
                    end else if (!w_stall) begin
                        w_deliver    = 1'b1;
                        w_pc_load    = 1'b1;
                        w_state_next = ST_REQ;
                    end else begin
                        w_hold_load  = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end else if (w_redirect) begin
                    w_pc_load    = 1'b1;
                    w_state_next = ST_KILL;
                end
            end
            ST_KILL: begin
                w_pc_load = w_redirect;
                if (imem.ImemRvalidF) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_HOLD: begin
                w_del_instr = r_hold_instr;
                w_del_pc    = r_hold_pc;
                w_del_pc4   = r_hold_pc4;
                if (w_redirect) begin
                    w_pc_load    = 1'b1;
                    w_state_next = ST_REQ;
                end else if (!w_stall) begin
                    w_deliver    = 1'b1;
                    w_pc_load    = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            default: w_state_next = ST_REQ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_REQ;
            r_pcf   <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            if (w_pc_load) begin
                r_pcf <= w_pc_target;
            end
        end
    end

    // NOTE: the hold buffer is cleared on reset even though it is always
    // written before being read, so its contents are never X in simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_instr <= 32'd0;
            r_hold_pc    <= 64'd0;
            r_hold_pc4   <= 64'd0;
        end else if (w_hold_load) begin
            r_hold_instr <= imem.ImemRdataF;
            r_hold_pc    <= r_pcf;
            r_hold_pc4   <= w_pc_plus4;
        end
    end

    // IF/ID register: flush beats stall beats delivery beats bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_d <= NOP_INSTR;
            r_pc_d    <= 64'd0;
            r_pc4_d   <= 64'd0;
            r_valid_d <= 1'b0;
        end else if (FlushD) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (!StallD) begin
            if (w_deliver) begin
                r_instr_d <= w_del_instr;
                r_pc_d    <= w_del_pc;
                r_pc4_d   <= w_del_pc4;
                r_valid_d <= 1'b1;
            end else begin
                r_instr_d <= NOP_INSTR;
                r_valid_d <= 1'b0;
            end
        end
    end

    // The request is masked while reset is held even though the state
    // register already sits in REQ.
    assign imem.ImemReqF  = rst_n && (r_state == ST_REQ);
    assign imem.ImemAddrF = r_pcf;

    assign PCF      = r_pcf;
    assign PCPlus4F = w_pc_plus4;
    assign InstrD   = r_instr_d;
    assign PCD      = r_pc_d;
    assign PCPlus4D = r_pc4_d;
    assign ValidD   = r_valid_d;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit : self-checking bench for fetch_unit.
//
// A transaction-level reference model (outstanding / wrong-path / held
// bookkeeping) predicts every output; a compare process checks the DUT
// against it on each falling edge. Directed sequences pin the model with
// literal values, then a randomized phase drives a memory model with
// random latency, redirects, stalls and flushes.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] PCnext = '0;
    logic [1:0]  PCSrcE = '0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic [63:0] PCF, PCPlus4F, PCD, PCPlus4D;
    logic [31:0] InstrD;
    logic        ValidD;

    fetch_unit_if imem_bus ();

    fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .PCnext   (PCnext),
        .PCSrcE   (PCSrcE),
        .StallD   (StallD),
        .FlushD   (FlushD),
        .imem     (imem_bus.master),
        .PCF      (PCF),
        .PCPlus4F (PCPlus4F),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_pc;
    bit          m_out;      // a request has been accepted, response owed
    bit          m_wrong;    // that owed response is on an abandoned path
    bit          m_held;     // a response is parked waiting for decode
    logic [31:0] m_h_instr;
    logic [63:0] m_h_pc;
    logic [31:0] m_instr_d;
    logic [63:0] m_pc_d, m_pc4_d;
    bit          m_valid_d;

    task automatic m_reset();
        m_pc = RST_PC; m_out = 0; m_wrong = 0; m_held = 0;
        m_h_instr = '0; m_h_pc = '0;
        m_instr_d = NOP; m_pc_d = '0; m_pc4_d = '0; m_valid_d = 0;
    endtask

    task automatic m_step();
        bit          redir = (PCSrcE != 2'd0);
        bit          stall_eff = StallD && !FlushD;
        logic [63:0] target = {PCnext[63:2], 2'b00};
        bit          deliver = 0;
        logic [31:0] d_instr = '0;
        logic [63:0] d_pc = '0;
        if (!m_out && !m_held) begin
            if (imem_bus.ImemReadyF) begin
                m_out = 1; m_wrong = redir;
            end
            if (redir) m_pc = target;
        end else if (m_out && !m_wrong) begin
            if (imem_bus.ImemRvalidF) begin
                m_out = 0;
                if (redir) m_pc = target;
                else if (!stall_eff) begin
                    deliver = 1; d_instr = imem_bus.ImemRdataF; d_pc = m_pc; m_pc = target;
                end else begin
                    m_held = 1; m_h_instr = imem_bus.ImemRdataF; m_h_pc = m_pc;
                end
            end else if (redir) begin
                m_wrong = 1; m_pc = target;
            end
        end else if (m_out) begin
            if (redir) m_pc = target;
            if (imem_bus.ImemRvalidF) begin m_out = 0; m_wrong = 0; end
        end else begin
            if (redir) begin
                m_held = 0; m_pc = target;
            end else if (!stall_eff) begin
                m_held = 0; deliver = 1; d_instr = m_h_instr; d_pc = m_h_pc; m_pc = target;
            end
        end
        if (FlushD) begin
            m_instr_d = NOP; m_valid_d = 0;
        end else if (!StallD) begin
            if (deliver) begin
                m_instr_d = d_instr; m_pc_d = d_pc; m_pc4_d = d_pc + 64'd4; m_valid_d = 1;
            end else begin
                m_instr_d = NOP; m_valid_d = 0;
            end
        end
    endtask

    always @(posedge clk) if (chk_en && rst_n) m_step();

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("PCF",       PCF,                 m_pc);
            check("PCPlus4F",  PCPlus4F,            m_pc + 64'd4);
            check("ImemReqF",  {63'd0, imem_bus.ImemReqF}, {63'd0, rst_n && !m_out && !m_held});
            check("ImemAddrF", imem_bus.ImemAddrF,  m_pc);
            check("InstrD",    {32'd0, InstrD},     {32'd0, m_instr_d});
            check("PCD",       PCD,                 m_pc_d);
            check("PCPlus4D",  PCPlus4D,            m_pc4_d);
            check("ValidD",    {63'd0, ValidD},     {63'd0, m_valid_d});
        end
    end

    // ---------------- stimulus ----------------
    // Drive one cycle at posedge+1 and return at the next posedge+1.
    // With src==0 the mux output is the sequential PC+4, as the real mux does.
    task automatic cyc(input bit rdy, input bit rv, input logic [31:0] rd,
                       input logic [1:0] src, input logic [63:0] nxt,
                       input bit st, input bit fl);
        imem_bus.ImemReadyF  = rdy;
        imem_bus.ImemRvalidF = rv;
        imem_bus.ImemRdataF  = rd;
        PCSrcE = src;
        PCnext = (src == 2'd0) ? m_pc + 64'd4 : nxt;
        StallD = st;
        FlushD = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
    endfunction

    localparam logic [31:0] I_A = 32'h0050_0093;
    localparam logic [31:0] I_B = 32'h00a0_0113;
    localparam logic [31:0] I_C = 32'hdead_beef;
    localparam logic [31:0] I_E = 32'h0010_0193;
    localparam logic [31:0] I_D = 32'h0030_0213;
    localparam logic [31:0] I_F = 32'h0040_0293;
    localparam logic [31:0] I_G = 32'h0060_0313;
    localparam logic [31:0] I_H = 32'h0070_0393;

    bit          mem_pending;
    int          mem_delay;
    logic [63:0] mem_addr;

    initial begin
        imem_bus.ImemReadyF  = 1'b0;
        imem_bus.ImemRvalidF = 1'b0;
        imem_bus.ImemRdataF  = '0;
        m_reset();
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check("rst PCF",      PCF, RST_PC);
        check("rst ReqF",     {63'd0, imem_bus.ImemReqF}, 64'd0);
        check("rst InstrD",   {32'd0, InstrD}, {32'd0, NOP});
        check("rst ValidD",   {63'd0, ValidD}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: sequential fetch, 1-cycle memory
        cyc(1, 0, '0, 0, '0, 0, 0);
        cyc(0, 1, I_A, 0, '0, 0, 0);
        check("t1 PCD A",    PCD, 64'h1000);
        check("t1 InstrD A", {32'd0, InstrD}, {32'd0, I_A});
        check("t1 ValidD A", {63'd0, ValidD}, 64'd1);
        cyc(1, 0, '0, 0, '0, 0, 0);
        check("t1 bubble",   {63'd0, ValidD}, 64'd0);
        cyc(0, 1, I_B, 0, '0, 0, 0);
        check("t1 PCD B",    PCD, 64'h1004);
        check("t1 InstrD B", {32'd0, InstrD}, {32'd0, I_B});
        check("t1 PCPlus4D", PCPlus4D, 64'h1008);

        // 2: redirect while waiting, wrong-path response dropped
        cyc(1, 0, '0, 0, '0, 0, 0);
        cyc(0, 0, '0, 1, 64'h2000, 0, 0);
        check("t2 PCF",      PCF, 64'h2000);
        check("t2 ReqF",     {63'd0, imem_bus.ImemReqF}, 64'd0);
        cyc(0, 1, I_C, 0, '0, 0, 0);
        check("t2 C dropped", {63'd0, ValidD}, 64'd0);
        check("t2 AddrF",    imem_bus.ImemAddrF, 64'h2000);
        cyc(1, 0, '0, 0, '0, 0, 0);
        cyc(0, 1, I_E, 0, '0, 0, 0);
        check("t2 PCD",      PCD, 64'h2000);
        check("t2 InstrD",   {32'd0, InstrD}, {32'd0, I_E});

        // 3: accept and redirect in the same REQ cycle, low bits masked
        cyc(1, 0, '0, 2, 64'h3002, 0, 0);
        check("t3 PCF",      PCF, 64'h3000);
        check("t3 ReqF",     {63'd0, imem_bus.ImemReqF}, 64'd0);
        cyc(0, 1, I_C, 0, '0, 0, 0);
        check("t3 dropped",  {63'd0, ValidD}, 64'd0);
        check("t3 ReqF2",    {63'd0, imem_bus.ImemReqF}, 64'd1);

        // 4: stall when response D returns at 0x1010, held 3 cycles
        cyc(0, 0, '0, 1, 64'h1010, 0, 0);
        cyc(1, 0, '0, 0, '0, 0, 0);
        cyc(0, 1, I_D, 0, '0, 1, 0);
        cyc(0, 0, '0, 0, '0, 1, 0);
        cyc(0, 0, '0, 0, '0, 1, 0);
        check("t4 PCF held", PCF, 64'h1010);
        check("t4 PCD held", PCD, 64'h2000);
        check("t4 Valid held", {63'd0, ValidD}, 64'd0);
        cyc(0, 0, '0, 0, '0, 0, 0);
        check("t4 PCD",      PCD, 64'h1010);
        check("t4 InstrD",   {32'd0, InstrD}, {32'd0, I_D});
        check("t4 AddrF",    imem_bus.ImemAddrF, 64'h1014);

        // 5: flush + stall on a delivery cycle: instruction lost
        cyc(1, 0, '0, 0, '0, 0, 0);
        cyc(0, 1, I_F, 0, '0, 1, 1);
        check("t5 InstrD",   {32'd0, InstrD}, 64'h13);
        check("t5 ValidD",   {63'd0, ValidD}, 64'd0);
        cyc(1, 0, '0, 0, '0, 0, 0);
        cyc(0, 1, I_G, 0, '0, 0, 0);
        check("t5 next PCD", PCD, 64'h1018);
        check("t5 next Instr", {32'd0, InstrD}, {32'd0, I_G});

        // 6: reset mid-transaction, stale response ignored
        cyc(1, 0, '0, 0, '0, 0, 0);
        #3 rst_n = 1'b0;
        m_reset();
        #1;
        check("t6 PCF",      PCF, RST_PC);
        check("t6 ReqF",     {63'd0, imem_bus.ImemReqF}, 64'd0);
        check("t6 PCD",      PCD, 64'd0);
        check("t6 InstrD",   {32'd0, InstrD}, {32'd0, NOP});
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(0, 1, I_C, 0, '0, 0, 0);
        check("t6 stale",    {63'd0, ValidD}, 64'd0);
        check("t6 AddrF",    imem_bus.ImemAddrF, RST_PC);
        cyc(1, 0, '0, 0, '0, 0, 0);
        cyc(0, 1, I_H, 0, '0, 0, 0);
        check("t6 PCD",      PCD, RST_PC);
        check("t6 InstrD",   {32'd0, InstrD}, {32'd0, I_H});

        // Random phase: memory with 0..2 extra cycles of latency
        mem_pending = 0;
        mem_delay   = 0;
        mem_addr    = '0;
        for (int i = 0; i < 3000; i++) begin
            bit          rdy = ($urandom_range(0, 3) != 0);
            bit          rv  = 0;
            logic [31:0] rd  = $urandom;
            logic [1:0]  src = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            logic [63:0] nxt = {$urandom, $urandom};
            bit          st  = ($urandom_range(0, 4) == 0);
            bit          fl  = ($urandom_range(0, 9) == 0);
            if (mem_pending) begin
                if (mem_delay == 0) begin
                    rv = 1; rd = word_of(mem_addr); mem_pending = 0;
                end else begin
                    mem_delay--;
                end
            end else if (imem_bus.ImemReqF && rdy) begin
                mem_pending = 1;
                mem_addr    = imem_bus.ImemAddrF;
                mem_delay   = $urandom_range(0, 2);
            end
            cyc(rdy, rv, rd, src, nxt, st, fl);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
